// File: rtl/svm_pkg.sv
// Shared types and width helpers for the printed-ML SVM scorers.
package svm_pkg;

  // Scorer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Index width that is never narrower than one bit.
  function automatic int unsigned cls_w_f(input int unsigned n);
    return (clog2_f(n) < 1) ? 1 : clog2_f(n);
  endfunction

endpackage

// File: rtl/svm_mac_unit.sv
// Combinational signed MAC: acc + (zero-extended feature * signed weight),
// product formed at IN_W+W_W+1 bits and sign-extended into the accumulator.
module svm_mac_unit #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned W_W   = 8,
  parameter int unsigned ACC_W = 14
) (
  input  logic        [IN_W-1:0]  x_i,
  input  logic signed [W_W-1:0]   w_i,
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] sum_c
);

  localparam int unsigned PROD_W = IN_W + W_W + 1;

  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] w_ext;
  logic signed [PROD_W-1:0] prod;

  // Feature is unsigned, so it gets a zero MSB before entering signed math.
  assign x_ext = $signed(PROD_W'({1'b0, x_i}));
  assign w_ext = PROD_W'(w_i);
  assign prod  = x_ext * w_ext;
  // Wraps modulo 2^ACC_W; no saturation.
  assign sum_c = acc_i + ACC_W'(prod);

endmodule

// File: rtl/svm_seq_linear_core.sv
// Time-multiplexed linear SVM scorer: one MAC walks every feature of every
// output channel, adds the channel intercept and optionally picks a class.
module svm_seq_linear_core
  import svm_pkg::*;
#(
  parameter int unsigned                          NUM_FEAT   = 11,
  parameter int unsigned                          IN_W       = 4,
  parameter int unsigned                          W_W        = 8,
  parameter int unsigned                          ACC_W      = 14,
  parameter int unsigned                          NUM_OUT    = 1,
  parameter logic [NUM_OUT*NUM_FEAT*W_W-1:0]      WEIGHTS    = 88'h4127_FDF1_E908_E70D_FAD4_11,
  parameter logic [NUM_OUT*ACC_W-1:0]             INTERCEPTS = 14'd2763,
  parameter bit                                   CLASSIFY   = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_FEAT*IN_W-1:0]          inp,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_OUT*ACC_W-1:0]          out,
  output logic [cls_w_f(NUM_OUT)-1:0]       class_out
);

  localparam int unsigned CLS_W  = cls_w_f(NUM_OUT);
  localparam int unsigned FEAT_W = cls_w_f(NUM_FEAT);
  localparam int unsigned CH_W   = cls_w_f(NUM_OUT);
  localparam int unsigned X_W    = NUM_FEAT * IN_W;
  localparam int unsigned OUT_W  = NUM_OUT * ACC_W;
  localparam logic [ACC_W-1:0] ACC_ONES = '1;

  state_e                    state_q, state_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic [X_W-1:0]            x_q, x_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [FEAT_W-1:0]         feat_q, feat_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [OUT_W-1:0]          out_q, out_d;
  logic [CLS_W-1:0]          cls_q, cls_d;

  logic [IN_W-1:0]           x_sel;
  logic signed [W_W-1:0]     w_sel;
  logic signed [ACC_W-1:0]   icpt_first;
  logic signed [ACC_W-1:0]   icpt_next;
  logic signed [ACC_W-1:0]   sum_c;
  logic [OUT_W-1:0]          out_wr_c;
  logic [CLS_W-1:0]          cls_c;
  logic [31:0]               x_base;
  logic [31:0]               w_base;
  logic [31:0]               o_base;
  logic [31:0]               i_base;
  logic                      last_feat;
  logic                      last_ch;

  // Operand selection for the current feature/channel.
  assign x_base     = 32'(feat_q) * IN_W;
  assign w_base     = (32'(ch_q) * NUM_FEAT + 32'(feat_q)) * W_W;
  assign o_base     = 32'(ch_q) * ACC_W;
  assign i_base     = (32'(ch_q) + 32'd1) * ACC_W;
  assign x_sel      = IN_W'(x_q >> x_base);
  assign w_sel      = $signed(W_W'(WEIGHTS >> w_base));
  assign icpt_first = $signed(INTERCEPTS[ACC_W-1:0]);
  assign icpt_next  = $signed(ACC_W'(INTERCEPTS >> i_base));
  assign last_feat  = (feat_q == FEAT_W'(NUM_FEAT - 1));
  assign last_ch    = (ch_q == CH_W'(NUM_OUT - 1));

  svm_mac_unit #(
    .IN_W  (IN_W),
    .W_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .x_i   (x_sel),
    .w_i   (w_sel),
    .acc_i (acc_q),
    .sum_c (sum_c)
  );

  // Score vector with the current channel's running sum written in.
  always_comb begin
    out_wr_c = (out_q & ~(OUT_W'(ACC_ONES) << o_base))
             | (OUT_W'($unsigned(sum_c)) << o_base);
  end

  // Decision on the final score vector: sign for one channel, else argmax
  // with ties resolved toward the lowest index.
  always_comb begin
    logic signed [ACC_W-1:0] best;
    logic signed [ACC_W-1:0] cand;
    cls_c = '0;
    best  = $signed(out_wr_c[ACC_W-1:0]);
    cand  = best;
    if (NUM_OUT == 1) begin
      cls_c = CLS_W'(~out_wr_c[ACC_W-1]);
    end else begin
      for (int unsigned c = 1; c < NUM_OUT; c++) begin
        cand = $signed(ACC_W'(out_wr_c >> (c * ACC_W)));
        if (cand > best) begin
          best  = cand;
          cls_c = CLS_W'(c);
        end
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    acc_d       = acc_q;
    feat_d      = feat_q;
    ch_d        = ch_q;
    out_d       = out_q;
    cls_d       = cls_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d        = inp;
          acc_d      = icpt_first;
          feat_d     = '0;
          ch_d       = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        acc_d  = sum_c;
        feat_d = feat_q + FEAT_W'(1);
        if (last_feat) begin
          out_d = out_wr_c;
          if (last_ch) begin
            out_valid_d = 1'b1;
            if (CLASSIFY) cls_d = cls_c;
            state_d = DONE;
          end else begin
            ch_d   = ch_q + CH_W'(1);
            feat_d = '0;
            acc_d  = icpt_next;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any computation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      acc_q       <= '0;
      feat_q      <= '0;
      ch_q        <= '0;
      out_q       <= '0;
      cls_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      feat_q      <= feat_d;
      ch_q        <= ch_d;
      out_q       <= out_d;
      cls_q       <= cls_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign class_out = cls_q;

endmodule

// File: tb/tb_svm_seq_linear_core.sv
// Directed bench for svm_seq_linear_core over four parameter sets.
module tb_svm_seq_linear_core;

  logic        clk;
  logic        rst_n;
  logic [3:0]  iv;
  logic [3:0]  ir;
  logic [3:0]  ov;
  logic        out_ready;
  logic [43:0] inp;
  logic [13:0] out0, out1, out2;
  logic [41:0] out3;
  logic        cls0, cls1, cls2;
  logic [1:0]  cls3;

  int checks = 0;
  int errors = 0;
  int lat;

  // Default weights/intercept, classify on.
  svm_seq_linear_core #(.CLASSIFY(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .inp(inp),
    .out_valid(ov[0]), .out_ready(out_ready), .out(out0), .class_out(cls0));

  // Negative intercept, classify on.
  svm_seq_linear_core #(.INTERCEPTS(14'h3F9C), .CLASSIFY(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .inp(inp),
    .out_valid(ov[1]), .out_ready(out_ready), .out(out1), .class_out(cls1));

  // Intercept at the positive limit to force a wrap, classify off.
  svm_seq_linear_core #(.INTERCEPTS(14'd8191)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .inp(inp),
    .out_valid(ov[2]), .out_ready(out_ready), .out(out2), .class_out(cls2));

  // Three channels, zero weights, tied top scores.
  svm_seq_linear_core #(
    .NUM_OUT(3), .WEIGHTS(264'd0),
    .INTERCEPTS({14'd500, 14'd500, 14'd10}), .CLASSIFY(1'b1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .inp(inp),
    .out_valid(ov[3]), .out_ready(out_ready), .out(out3), .class_out(cls3));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one vector to instance k; lat counts cycles from the presenting
  // cycle (0) to the first cycle with out_valid high.
  task automatic run(input int k, input logic [43:0] vec, output int l);
    @(negedge clk);
    inp   = vec;
    iv[k] = 1'b1;
    l     = 0;
    @(negedge clk);
    iv[k] = 1'b0;
    l     = 1;
    while (!ov[k] && l < 200) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; iv = '0; out_ready = 1'b1; inp = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(ir), 64'hF);
    check("rst_out_valid", 64'(ov), 64'h0);
    check("rst_out0", 64'(out0), 64'd0);
    check("rst_out3", 64'(out3), 64'd0);
    check("rst_cls", 64'({cls0, cls1, cls2, cls3}), 64'd0);
    rst_n = 1'b1;

    // Zero features -> intercept only.
    run(0, 44'h0, lat);
    check("zero_latency", 64'(lat), 64'd12);
    check("zero_out", 64'(out0), 64'(14'd2763));
    check("zero_cls", 64'(cls0), 64'd1);
    @(negedge clk);
    check("zero_valid_one_cycle", 64'(ov[0]), 64'd0);
    check("zero_ready_back", 64'(ir[0]), 64'd1);

    // All features 15 -> 2763 + 15*26.
    run(0, 44'hFFF_FFFF_FFFF, lat);
    check("all15_out", 64'(out0), 64'(14'd3153));
    check("all15_cls", 64'(cls0), 64'd1);

    // Feature 1 alone = 15 -> 2763 - 660.
    run(0, 44'h000_0000_00F0, lat);
    check("f1_latency", 64'(lat), 64'd12);
    check("f1_out", 64'(out0), 64'(14'd2103));
    check("f1_cls", 64'(cls0), 64'd1);

    // Negative intercept.
    run(1, 44'h0, lat);
    check("neg_out", 64'(out1), 64'(14'h3F9C));
    check("neg_cls", 64'(cls1), 64'd0);

    // 8191 + 65 wraps to -8128.
    run(2, 44'h100_0000_0000, lat);
    check("wrap_out", 64'(out2), 64'(14'h2040));
    check("wrap_cls_disabled", 64'(cls2), 64'd0);

    // Three channels with tie between channels 1 and 2.
    run(3, 44'h123_4567_89AB, lat);
    check("mc_latency", 64'(lat), 64'd34);
    check("mc_out", 64'(out3), 64'({14'd500, 14'd500, 14'd10}));
    check("mc_cls_tie_low", 64'(cls3), 64'd1);
    @(negedge clk);

    // Backpressure: result held, inputs ignored while DONE.
    out_ready = 1'b0;
    run(0, 44'h000_0000_0001, lat);
    check("bp_out", 64'(out0), 64'(14'd2780));
    for (int i = 0; i < 5; i++) begin
      iv[0] = (i % 2 == 0) && (i < 4);
      inp   = 44'hFFF_FFFF_FFFF;
      @(negedge clk);
      check("bp_hold_valid", 64'(ov[0]), 64'd1);
      check("bp_hold_out", 64'(out0), 64'(14'd2780));
      check("bp_hold_ready", 64'(ir[0]), 64'd0);
    end
    iv[0] = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(ov[0]), 64'd0);
    check("bp_release_ready", 64'(ir[0]), 64'd1);
    check("bp_out_kept", 64'(out0), 64'(14'd2780));
    @(negedge clk);
    check("bp_no_accept", 64'(ir[0]), 64'd1);

    // Reset in the middle of RUN.
    @(negedge clk);
    inp = 44'hFFF_FFFF_FFFF;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun_busy", 64'(ir[0]), 64'd0);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out", 64'(out0), 64'd0);
    check("midrun_rst_valid", 64'(ov[0]), 64'd0);
    check("midrun_rst_ready", 64'(ir[0]), 64'd1);
    check("midrun_rst_cls", 64'(cls0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 44'h000_0000_00F0, lat);
    check("post_rst_latency", 64'(lat), 64'd12);
    check("post_rst_out", 64'(out0), 64'(14'd2103));
    check("post_rst_cls", 64'(cls0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/svm_seq_linear_core.md
Name: svm_seq_linear_core

Overview:
- Time-multiplexed, parametrised linear SVM scorer (regression or classification) for the printed-ML classifier family.
- One signed MAC replaces per-feature multipliers. It walks NUM_FEAT features for each of NUM_OUT output channels and adds the per-channel intercept.
- A valid/ready handshake on each side lets it sit between a feature-capture front end and a decision/readout stage.
- In classify mode it also emits a class index.

Parameters:
- NUM_FEAT, 11, number of input features.
- IN_W, 4, unsigned width of each feature.
- W_W, 8, signed width of each weight.
- ACC_W, 14, signed accumulator and score width.
- NUM_OUT, 1, number of output channels (classes or regressors).
- WEIGHTS, packed NUM_OUT*NUM_FEAT*W_W; default is channel 0 = {17,-44,-6,13,-25,8,-23,-15,-3,39,65}. Entry [c][f] sits at bits ((c*NUM_FEAT+f)*W_W)+:W_W.
- INTERCEPTS, packed NUM_OUT*ACC_W, default channel 0 = 2763. Channel c sits at bits (c*ACC_W)+:ACC_W.
- CLASSIFY, 0; 1 enables the class_out decision logic (class_out reads 0 when CLASSIFY=0).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1, feature vector valid.
- in_ready, output, 1, core can accept a vector.
- inp, input, NUM_FEAT*IN_W, feature f at bits (f*IN_W)+:IN_W, unsigned.
- out_valid, output, 1, scores and class valid.
- out_ready, input, 1, consumer accepts the result.
- out, output, NUM_OUT*ACC_W, signed score of channel c at bits (c*ACC_W)+:ACC_W.
- class_out, output, CLS_W = max(1, clog2(NUM_OUT)), decision.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out=0, class_out=0, acc=0, feat=0, ch=0.
- State machine has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch inp, acc<=INTERCEPTS[0], feat<=0, ch<=0, go to RUN.
- RUN:
  - in_ready=0. Each cycle: acc<=acc+sext(x[feat])*W[ch][feat], with the feature zero-extended to signed.
  - The product is formed at IN_W+W_W+1 bits and sign-extended to ACC_W.
  - Sums wrap modulo 2^ACC_W (two's complement); there is no saturation.
  - When feat==NUM_FEAT-1:
    - out[ch] <= final sum.
    - If ch==NUM_OUT-1, go to DONE.
    - Otherwise ch<=ch+1, feat<=0, acc<=INTERCEPTS[ch+1].
- DONE:
  - out_valid=1; out and class_out are stable.
  - On out_ready: out_valid<=0, go to IDLE. out keeps its last value.
- Latency:
  - The handshake edge is cycle 0.
  - out_valid rises at cycle NUM_FEAT*NUM_OUT+1 (12 for the defaults).
  - Throughput is one vector per NUM_FEAT*NUM_OUT+2 cycles when out_ready is held high.
- class_out (CLASSIFY=1) is registered on entry to DONE:
  - NUM_OUT==1: class_out = 1 if score>=0, else 0.
  - NUM_OUT>1: index of the maximum signed score; ties go to the lowest index.
- Inputs are ignored outside IDLE. inp changing during RUN has no effect.
- out_ready while out_valid=0 is ignored.
- A deasserted rst_n mid-RUN or mid-DONE aborts the computation and returns all outputs to their reset values. No partial result is ever flagged valid.
- NUM_FEAT=1 is legal; RUN lasts one cycle per channel.

Decomposition:
- Shared package svm_pkg:
  - state typedef (IDLE/RUN/DONE);
  - width helpers: clog2 and CLS_W.
- One sub-module, svm_mac_unit (combinational signed multiply plus ACC_W add). It is reusable by the other printed classifiers.
- Weight and intercept slicing stays in the core.

Test Plan:
- Defaults, inp all 0, out_ready=1 -> out=2763, out_valid rises exactly 12 cycles after accept and stays high for one cycle.
- Defaults, all features 15 -> out=2763+15*26=3153. Feature 1 alone =15 -> out=2103. With CLASSIFY=1, class_out=1 in both cases.
- INTERCEPTS=-100, CLASSIFY=1, inp 0 -> out=-100 (14'h3F9C), class_out=0. INTERCEPTS=8191, feature 10=1, others 0 -> out=-8128 (wrap).
- NUM_OUT=3, channel intercepts {10,500,500}, weights 0 -> out={500,500,10}, class_out=1 (tie goes low), latency 34.
- out_ready held low 5 cycles in DONE -> out_valid and out stable, in_ready=0, in_valid pulses ignored. Result releases on the first out_ready cycle.
- rst_n pulsed low at RUN cycle 5 -> outputs go to 0 immediately. The next vector after release gives the correct score with no carry-over.
